// File: rtl/gbe_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gbe_tx_arb_pkg
// Description : Shared types and helpers for the gbe_udp TX packet arbiter.
//               Holds the arbiter state encoding, the packet length counter
//               width and the source-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gbe_tx_arb_pkg;

    // Width of the per-packet byte counter (saturating)
    localparam int LEN_W = 16;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } arb_state_e;

    // Bits needed to index NUM_SRC sources, never less than one
    function automatic int SRC_IDX_W(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gbe_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gbe_rr_pick
// Description : Combinational round-robin selector. Scans the request vector
//               starting at rr_ptr_i, ascending with wrap, and returns the
//               first requester as a one-hot grant and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module gbe_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan from the farthest position back to rr_ptr so the last hit
    // written is the nearest requester at or after the pointer.
    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_i) + k) % NUM_SRC;
            if (req_i[j]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(j);
                grant_o    = '0;
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gbe_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gbe_tx_arbiter
// Description : Packet-level round-robin arbiter sharing the gbe_udp
//               application TX port among NUM_SRC sources. Grants at packet
//               boundaries, muxes data/destination, throttles on afull,
//               truncates packets longer than MAX_LEN and reports status.
// Revision    : 1.0 - initial release
// ============================================================================
module gbe_tx_arbiter
    import gbe_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 1472
) (
    input  logic                  app_clk,
    input  logic                  app_rst,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [NUM_SRC*8-1:0]  src_data,
    input  logic [NUM_SRC-1:0]    src_dvld,
    input  logic [NUM_SRC-1:0]    src_eof,
    input  logic [NUM_SRC*32-1:0] src_destip,
    input  logic [NUM_SRC*16-1:0] src_destport,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [7:0]            app_tx_data,
    output logic                  app_tx_dvld,
    output logic                  app_tx_eof,
    output logic [31:0]           app_tx_destip,
    output logic [15:0]           app_tx_destport,
    input  logic                  app_tx_afull,
    input  logic                  app_tx_overflow,
    output logic                  err_trunc,
    output logic [2:0]            err_src,
    output logic                  ovf_sticky
);

    localparam int              IDX_W    = SRC_IDX_W(NUM_SRC);
    localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_SAT  = {LEN_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e         state_q;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [LEN_W-1:0]   len_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [31:0]        destip_q;
    logic [15:0]        destport_q;
    logic               err_trunc_q;
    logic [2:0]         err_src_q;
    logic               ovf_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               in_xfer;
    logic               in_drop;
    logic               sel_ready;
    logic               sel_dvld;
    logic               sel_eof;
    logic               xfer_fire;
    logic               at_last;
    logic [LEN_W-1:0]   len_d;
    logic [IDX_W-1:0]   rr_ptr_d;

    gbe_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (src_req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign in_xfer   = (state_q == ST_XFER);
    assign in_drop   = (state_q == ST_DROP);

    // Only the granted source is ever ready; afull pauses forwarding but
    // the discard phase keeps draining regardless of the TX buffer level.
    assign sel_ready = (in_xfer && !app_tx_afull) || in_drop;
    assign sel_dvld  = src_dvld[sel_q];
    assign sel_eof   = src_eof[sel_q];
    assign xfer_fire = sel_ready && sel_dvld;
    assign at_last   = (len_q == LAST_LEN);

    // Byte counter saturates rather than wrapping
    assign len_d     = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

    // Served source moves to the back of the round-robin order
    assign rr_ptr_d  = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

    // ------------------------------------------------------------------
    // Output mux: zero-latency path from the granted source to gbe_udp
    // ------------------------------------------------------------------
    assign src_grant       = grant_q;
    assign src_ready       = sel_ready ? grant_q : '0;
    assign app_tx_data     = in_xfer ? src_data[sel_q*8 +: 8] : 8'h00;
    assign app_tx_dvld     = in_xfer && xfer_fire;
    assign app_tx_eof      = app_tx_dvld && (sel_eof || at_last);
    assign app_tx_destip   = destip_q;
    assign app_tx_destport = destport_q;
    assign err_trunc       = err_trunc_q;
    assign err_src         = err_src_q;
    assign ovf_sticky      = ovf_q;

    // Arbiter FSM with length counter, destination latches and status
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            len_q       <= '0;
            grant_q     <= '0;
            destip_q    <= '0;
            destport_q  <= '0;
            err_trunc_q <= 1'b0;
            err_src_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            err_trunc_q <= 1'b0;

            if (app_tx_overflow) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // A new packet is only started when gbe_udp has room
                    if (pick_any && !app_tx_afull) begin
                        sel_q      <= pick_idx;
                        grant_q    <= pick_grant;
                        destip_q   <= src_destip[pick_idx*32 +: 32];
                        destport_q <= src_destport[pick_idx*16 +: 16];
                        len_q      <= '0;
                        state_q    <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (xfer_fire) begin
                        len_q <= len_d;
                        if (sel_eof) begin
                            // Normal end, including eof exactly on byte MAX_LEN
                            state_q  <= ST_IDLE;
                            grant_q  <= '0;
                            rr_ptr_q <= rr_ptr_d;
                        end else if (at_last) begin
                            // Forced eof went out with this byte; discard the rest
                            state_q     <= ST_DROP;
                            err_trunc_q <= 1'b1;
                            err_src_q   <= 3'(sel_q);
                        end
                    end
                end

                ST_DROP: begin
                    if (xfer_fire) begin
                        len_q <= len_d;
                        if (sel_eof) begin
                            state_q  <= ST_IDLE;
                            grant_q  <= '0;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gbe_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbe_tx_arbiter
// Description : Self-checking bench for gbe_tx_arbiter. Two instances share
//               the stimulus (MAX_LEN 1472 and MAX_LEN 8); requests are routed
//               to one of them at a time. A packet/cycle reference model
//               derived from the arbitration rules predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbe_tx_arbiter;

    localparam int N     = 4;
    localparam int MAX_A = 1472;
    localparam int MAX_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     src_req;
    logic [N-1:0]     src_dvld;
    logic [N-1:0]     src_eof;
    logic [N*8-1:0]   src_data;
    logic [N*32-1:0]  src_destip;
    logic [N*16-1:0]  src_destport;
    logic             afull;
    logic             ovf_in;
    logic             use_b;

    wire  [N-1:0]     req_a = use_b ? '0 : src_req;
    wire  [N-1:0]     req_b = use_b ? src_req : '0;

    logic [N-1:0] a_grant, a_ready, b_grant, b_ready;
    logic [7:0]   a_data, b_data;
    logic         a_dvld, a_eof, b_dvld, b_eof;
    logic [31:0]  a_ip, b_ip;
    logic [15:0]  a_port, b_port;
    logic         a_et, b_et, a_ovf, b_ovf;
    logic [2:0]   a_es, b_es;

    gbe_tx_arbiter #(.NUM_SRC(N), .MAX_LEN(MAX_A)) dut_a (
        .app_clk(clk), .app_rst(rst), .src_req(req_a), .src_data(src_data),
        .src_dvld(src_dvld), .src_eof(src_eof), .src_destip(src_destip),
        .src_destport(src_destport), .src_grant(a_grant), .src_ready(a_ready),
        .app_tx_data(a_data), .app_tx_dvld(a_dvld), .app_tx_eof(a_eof),
        .app_tx_destip(a_ip), .app_tx_destport(a_port), .app_tx_afull(afull),
        .app_tx_overflow(ovf_in), .err_trunc(a_et), .err_src(a_es), .ovf_sticky(a_ovf)
    );

    gbe_tx_arbiter #(.NUM_SRC(N), .MAX_LEN(MAX_B)) dut_b (
        .app_clk(clk), .app_rst(rst), .src_req(req_b), .src_data(src_data),
        .src_dvld(src_dvld), .src_eof(src_eof), .src_destip(src_destip),
        .src_destport(src_destport), .src_grant(b_grant), .src_ready(b_ready),
        .app_tx_data(b_data), .app_tx_dvld(b_dvld), .app_tx_eof(b_eof),
        .app_tx_destip(b_ip), .app_tx_destport(b_port), .app_tx_afull(afull),
        .app_tx_overflow(ovf_in), .err_trunc(b_et), .err_src(b_es), .ovf_sticky(b_ovf)
    );

    // Observed outputs of whichever instance currently owns the requests
    wire [N-1:0] o_grant = use_b ? b_grant : a_grant;
    wire [N-1:0] o_ready = use_b ? b_ready : a_ready;
    wire [7:0]   o_data  = use_b ? b_data  : a_data;
    wire         o_dvld  = use_b ? b_dvld  : a_dvld;
    wire         o_eof   = use_b ? b_eof   : a_eof;
    wire [31:0]  o_ip    = use_b ? b_ip    : a_ip;
    wire [15:0]  o_port  = use_b ? b_port  : a_port;
    wire         o_et    = use_b ? b_et    : a_et;
    wire [2:0]   o_es    = use_b ? b_es    : a_es;
    wire         o_ovf   = use_b ? b_ovf   : a_ovf;

    // Source behaviour: one outstanding packet per source
    int          s_len [N];
    int          s_pos [N];
    logic [7:0]  s_base[N];
    logic [31:0] s_ip  [N];
    logic [15:0] s_port[N];

    // Stimulus knobs
    int dv_pct, af_pct;
    bit rst_req, af_force, ovf_req;

    // Reference model
    int          m_cur, m_cnt;
    bit          m_tp;
    int          m_rr     [2];
    int          m_err_src[2];
    logic [31:0] m_ip     [2];
    logic [15:0] m_port   [2];
    bit          m_ovf    [2];

    // Observation counters
    int n_fwd, n_eof, n_trunc, n_paused, n_drop, n_gap;
    bit gap_en, seen_grant;
    logic [N-1:0] prev_grant;
    int order[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_fwd = 0; n_eof = 0; n_trunc = 0; n_paused = 0; n_drop = 0; n_gap = 0;
        seen_grant = 1'b0;
        order.delete();
    endtask

    task automatic start_pkt(input int i, input int len, input logic [7:0] base);
        s_len[i]  = len;
        s_pos[i]  = 0;
        s_base[i] = base;
        s_ip[i]   = $urandom;
        s_port[i] = 16'($urandom);
    endtask

    function automatic bit pending();
        bit p;
        p = (m_cur >= 0);
        for (int i = 0; i < N; i++) if (s_len[i] > 0) p = 1'b1;
        return p;
    endfunction

    // Compare outputs against the model just before the edge, then advance it
    task automatic sample();
        int           d, mx, w, j;
        logic [N-1:0] ge, re;
        bit           drop, tr, dv, eo;
        d  = use_b ? 1 : 0;
        mx = use_b ? MAX_B : MAX_A;
        ge = '0; re = '0; drop = 0; tr = 0; dv = 0; eo = 0;
        if (m_cur >= 0) begin
            ge[m_cur] = 1'b1;
            drop = (m_cnt >= mx);
            if (drop || !afull) re = ge;
            tr = src_dvld[m_cur] && re[m_cur];
            dv = tr && !drop;
            eo = dv && (src_eof[m_cur] || (m_cnt == mx - 1));
        end
        chk("grant", o_grant, ge);
        chk("ready", o_ready, re);
        chk("tx_dvld", o_dvld, dv);
        chk("tx_eof", o_eof, eo);
        if (dv) chk("tx_data", o_data, 8'(s_base[m_cur] + s_pos[m_cur]));
        chk("destip", o_ip, m_ip[d]);
        chk("destport", o_port, m_port[d]);
        chk("err_trunc", o_et, m_tp);
        chk("err_src", o_es, 3'(m_err_src[d]));
        chk("ovf_sticky", o_ovf, m_ovf[d]);

        if (o_dvld) n_fwd++;
        if (o_eof) n_eof++;
        if (o_et) n_trunc++;
        if (o_grant != '0 && o_ready == '0) n_paused++;
        if ((src_dvld & o_ready) != '0 && !o_dvld) n_drop++;
        if (gap_en && seen_grant && o_grant == '0 && src_req != '0) n_gap++;
        if (o_grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (o_grant[k]) order.push_back(k);
            seen_grant = 1'b1;
        end
        prev_grant = o_grant;

        if (rst) begin
            m_cur = -1; m_cnt = 0; m_tp = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_rr[k] = 0; m_err_src[k] = 0; m_ip[k] = '0; m_port[k] = '0; m_ovf[k] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin s_len[i] = 0; s_pos[i] = 0; end
        end else begin
            m_tp = 1'b0;
            if (ovf_in) begin m_ovf[0] = 1'b1; m_ovf[1] = 1'b1; end
            if (m_cur >= 0) begin
                if (dv && !src_eof[m_cur] && (m_cnt == mx - 1)) begin
                    m_tp = 1'b1;
                    m_err_src[d] = m_cur;
                end
                if (tr) begin
                    m_cnt++;
                    s_pos[m_cur]++;
                    if (src_eof[m_cur]) begin
                        m_rr[d] = (m_cur + 1) % N;
                        s_len[m_cur] = 0;
                        s_pos[m_cur] = 0;
                        m_cur = -1;
                    end
                end
            end else if (src_req != '0 && !afull) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr[d] + k) % N;
                    if (w < 0 && src_req[j]) w = j;
                end
                m_cur = w;
                m_cnt = 0;
                m_ip[d]   = src_destip[w*32 +: 32];
                m_port[d] = src_destport[w*16 +: 16];
            end
        end
    endtask

    // One clock: drive on the falling edge, check 1 ns before the rising edge
    task automatic step();
        @(negedge clk);
        rst    = rst_req;
        ovf_in = ovf_req;
        afull  = af_force || ($urandom_range(99) < af_pct);
        for (int i = 0; i < N; i++) begin
            src_destip[i*32 +: 32]   = s_ip[i];
            src_destport[i*16 +: 16] = s_port[i];
            src_req[i]  = (s_len[i] > 0);
            src_dvld[i] = (s_len[i] > 0) && ($urandom_range(99) < dv_pct);
            src_eof[i]  = src_dvld[i] && (s_pos[i] == s_len[i] - 1);
            src_data[i*8 +: 8] = src_dvld[i] ? 8'(s_base[i] + s_pos[i]) : 8'($urandom);
        end
        #4;
        sample();
    endtask

    task automatic drain(input int bound);
        int c;
        bit busy;
        c = 0;
        busy = pending();
        while (busy && c < bound) begin
            step();
            c++;
            busy = pending();
        end
        chk("drain_done", busy, 0);
        step();
    endtask

    task automatic rand_phase(input int cycles, input int maxl);
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < N; i++)
                if (s_len[i] == 0 && $urandom_range(3) == 0)
                    start_pkt(i, $urandom_range(maxl, 1), 8'($urandom));
        end
    endtask

    initial begin
        int exp_order[8];
        bit rs[N];
        int c;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst = 1'b1; src_req = '0; src_dvld = '0; src_eof = '0; src_data = '0;
        src_destip = '0; src_destport = '0; afull = 1'b0; ovf_in = 1'b0; use_b = 1'b0;
        rst_req = 1'b1; af_force = 1'b0; ovf_req = 1'b0; af_pct = 0; dv_pct = 100;
        gap_en = 1'b0; prev_grant = '0;
        m_cur = -1; m_cnt = 0; m_tp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rr[k] = 0; m_err_src[k] = 0; m_ip[k] = '0; m_port[k] = '0; m_ovf[k] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            s_len[i] = 0; s_pos[i] = 0; s_base[i] = '0; s_ip[i] = '0; s_port[i] = '0; rs[i] = 1'b0;
        end
        clr();

        // Reset state of both instances
        repeat (3) step();
        rst_req = 1'b0;
        step();
        chk("rst_a_grant", a_grant, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_ip", a_ip, 0);
        chk("rst_a_port", a_port, 0);
        chk("rst_b_grant", b_grant, 0);
        chk("rst_b_ovf", b_ovf, 0);

        // All four sources request 4-byte packets back to back
        clr();
        gap_en = 1'b1;
        for (int i = 0; i < N; i++) start_pkt(i, 4, 8'(i * 16));
        c = 0;
        while (c < 300 && (!(rs[0] && rs[1] && rs[2] && rs[3]) || pending())) begin
            step();
            c++;
            for (int i = 0; i < N; i++)
                if (s_len[i] == 0 && !rs[i]) begin
                    start_pkt(i, 4, 8'(8'h80 + i * 16));
                    rs[i] = 1'b1;
                end
        end
        step();
        gap_en = 1'b0;
        chk("rr_count", order.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < order.size()) chk($sformatf("rr_order%0d", k), order[k], exp_order[k]);
        chk("rr_gaps", n_gap, 7);

        // Single source, 10 bytes 0x00..0x09
        clr();
        start_pkt(0, 10, 8'h00);
        drain(100);
        chk("single_bytes", n_fwd, 10);
        chk("single_eofs", n_eof, 1);

        // afull held for 5 cycles mid-packet
        clr();
        start_pkt(1, 12, 8'h40);
        repeat (4) step();
        af_force = 1'b1;
        repeat (5) step();
        af_force = 1'b0;
        drain(100);
        chk("afull_paused", n_paused, 5);
        chk("afull_bytes", n_fwd, 12);
        chk("afull_eofs", n_eof, 1);

        // MAX_LEN 8: source 2 sends 12 bytes
        use_b = 1'b1;
        clr();
        start_pkt(2, 12, 8'h90);
        drain(100);
        chk("trunc_bytes", n_fwd, 8);
        chk("trunc_eofs", n_eof, 1);
        chk("trunc_pulses", n_trunc, 1);
        chk("trunc_src", o_es, 2);
        chk("trunc_dropped", n_drop, 4);

        // MAX_LEN 8: eof exactly on byte 8 is a normal end
        clr();
        start_pkt(3, 8, 8'hC0);
        drain(100);
        chk("exact_bytes", n_fwd, 8);
        chk("exact_trunc", n_trunc, 0);
        chk("exact_eofs", n_eof, 1);

        // Random traffic with random afull on both instances
        af_pct = 20;
        dv_pct = 70;
        rand_phase(400, 12);
        drain(3000);
        use_b = 1'b0;
        rand_phase(400, 20);
        drain(3000);
        af_pct = 0;
        dv_pct = 100;

        // Overflow pulse sets the sticky flag
        ovf_req = 1'b1;
        step();
        ovf_req = 1'b0;
        repeat (3) step();
        chk("ovf_held", o_ovf, 1);

        // Reset mid-packet after source 0 has moved the pointer past itself
        start_pkt(0, 6, 8'h10);
        drain(100);
        start_pkt(2, 10, 8'h20);
        repeat (4) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rstmid_grant", a_grant, 0);
        chk("rstmid_dvld", a_dvld, 0);
        chk("rstmid_ip", a_ip, 0);
        chk("rstmid_ovf", a_ovf, 0);
        chk("rstmid_et", a_et, 0);

        // Pointer back at 0: source 0 beats source 2
        clr();
        start_pkt(2, 3, 8'h30);
        start_pkt(0, 3, 8'h50);
        drain(100);
        chk("rstrr_count", order.size(), 2);
        if (order.size() >= 2) begin
            chk("rstrr_first", order[0], 0);
            chk("rstrr_second", order[1], 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
